// File: rtl/demux_sched.sv
// demux_sched: buffers (byte, destination) pairs in a small FIFO and sequences
// them onto the 8-line demux. Each byte is presented on dmx_in/dmx_sel, settles
// for one cycle, waits for its destination to be ready and is then committed
// with a one-cycle one-hot load strobe. A byte whose destination stays
// not-ready for TIMEOUT cycles is discarded and reported on drop.
module demux_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic [2:0]               in_dest,
  input  logic [7:0]               dst_ready,
  output logic [7:0]               dmx_in,
  output logic [2:0]               dmx_sel,
  output logic [7:0]               load,
  output logic                     drop,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Timer only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT<=1.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CT = CW'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] STROBE = 2'd3;

  logic [10:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    dmx_in_q, dmx_in_d;
  logic [2:0]    dmx_sel_q, dmx_sel_d;
  logic [7:0]    load_q, load_d;
  logic          drop_q, drop_d;
  logic          busy_q, busy_d;
  logic          push, pop;

  // No bypass: a full FIFO refuses the writer even if a pop happens this cycle.
  assign in_ready = clr_n & (count_q != FULL_CT);
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == IDLE) & (count_q != '0);

  // FIFO storage is written without reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_dest, in_data};
    end
  end

  // Next-state logic for the FIFO pointers/occupancy and the sequencing FSM.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    state_d   = state_q;
    timer_d   = timer_q;
    dmx_in_d  = dmx_in_q;
    dmx_sel_d = dmx_sel_q;
    load_d    = '0;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          {dmx_sel_d, dmx_in_d} = fifo_mem[rd_ptr_q];
          state_d               = SETUP;
        end
      end
      SETUP: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dst_ready[dmx_sel_q]) begin
          state_d = STROBE;
          load_d  = 8'd1 << dmx_sel_q;
        end else if ((TIMEOUT != 0) && (timer_q == TMAX)) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STROBE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) | (count_d != '0);
  end

  // State registers; reset discards the in-flight byte and every FIFO entry.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      dmx_in_q  <= '0;
      dmx_sel_q <= '0;
      load_q    <= '0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      dmx_in_q  <= dmx_in_d;
      dmx_sel_q <= dmx_sel_d;
      load_q    <= load_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  assign dmx_in  = dmx_in_q;
  assign dmx_sel = dmx_sel_q;
  assign load    = load_q;
  assign drop    = drop_q;
  assign busy    = busy_q;
  assign count   = count_q;

endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: directed and randomized stimulus for demux_sched. A queue of
// accepted (data, dest) pairs is the reference: every load must commit the
// queue head to its own destination, every drop must discard the head of a
// not-ready destination, in order.
module tb_demux_sched;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] dest;
  } ent_t;

  logic       clk;
  logic       clr_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic [7:0] dst_ready;
  logic [7:0] dmx_in;
  logic [2:0] dmx_sel;
  logic [7:0] load;
  logic       drop;
  logic       busy;
  logic [2:0] count;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_load = -1;
  int   n_load = 0;
  int   n_drop = 0;
  int   load_cycs[$];
  ent_t q[$];

  demux_sched #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .dst_ready(dst_ready),
    .dmx_in(dmx_in), .dmx_sel(dmx_sel), .load(load), .drop(drop),
    .busy(busy), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
  endtask

  // Advance one clock; record accepted pushes and score loads/drops against the queue.
  task automatic tick();
    logic acc;
    ent_t e;
    acc = in_valid && in_ready && clr_n;
    e.data = in_data;
    e.dest = in_dest;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) q.push_back(e);
    if (load != 8'h00) begin
      chk("load_no_drop", 32'(drop), 32'd0);
      chk("load_onehot", 32'($onehot(load)), 32'd1);
      chk("load_has_entry", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("load_dest", 32'(load), 32'(8'd1 << e.dest));
        chk("load_data", 32'(dmx_in), 32'(e.data));
        chk("load_sel", 32'(dmx_sel), 32'(e.dest));
        chk("load_ready", 32'(dst_ready[e.dest]), 32'd1);
      end
      if (last_load >= 0) chk("load_spacing", 32'(cyc - last_load >= 4), 32'd1);
      last_load = cyc;
      load_cycs.push_back(cyc);
      n_load++;
    end
    if (drop) begin
      chk("drop_has_entry", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("drop_not_ready", 32'(dst_ready[e.dest]), 32'd0);
      end
      n_drop++;
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 1000 && (q.size() != 0 || busy); k++) tick();
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int p;
    int ld0;
    int dr0;
    logic saw_full;
    clr_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_dest = 3'd0;
    dst_ready = 8'hFF;
    #2;
    // reset state
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_dmx_in", 32'(dmx_in), 32'd0);
    chk("rst_dmx_sel", 32'(dmx_sel), 32'd0);
    #10;
    clr_n = 1'b1;
    tick();

    // 1: single byte, best-case latency of three cycles
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 3'd3;
    tick();
    p = cyc;
    in_valid = 1'b0;
    tick(); chk("t1_early_load1", 32'(load), 32'd0);
    tick(); chk("t1_early_load2", 32'(load), 32'd0);
    tick();
    chk("t1_load", 32'(load), 32'h08);
    chk("t1_dmx_in", 32'(dmx_in), 32'hA5);
    chk("t1_dmx_sel", 32'(dmx_sel), 32'd3);
    chk("t1_latency", 32'(cyc - p), 32'd3);
    tick();
    chk("t1_load_off", 32'(load), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);

    // 2: eight back-to-back bytes, one per destination
    load_cycs.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i); in_dest = 3'(i);
      for (int k = 0; k < 20; k++) begin
        if (in_ready) begin
          tick();
          break;
        end
        if (!saw_full) begin
          saw_full = 1'b1;
          chk("t2_full_count", 32'(count), 32'd4);
        end
        tick();
      end
    end
    in_valid = 1'b0;
    drain("t2");
    chk("t2_saw_full", 32'(saw_full), 32'd1);
    chk("t2_num_loads", 32'(load_cycs.size()), 32'd8);
    for (int i = 1; i < load_cycs.size(); i++)
      chk("t2_gap", 32'(load_cycs[i] - load_cycs[i-1]), 32'd4);

    // 3: destination never ready -> drop after 15 WAIT cycles, next entry served
    dst_ready = 8'hDF;
    dr0 = n_drop; ld0 = n_load;
    in_valid = 1'b1; in_data = 8'h55; in_dest = 3'd5;
    tick();
    p = cyc;
    in_data = 8'h11; in_dest = 3'd1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && n_drop == dr0; k++) tick();
    chk("t3_dropped", 32'(n_drop - dr0), 32'd1);
    chk("t3_drop_time", 32'(cyc - p), 32'd17);
    tick();
    chk("t3_drop_pulse", 32'(drop), 32'd0);
    drain("t3");
    chk("t3_next_loaded", 32'(n_load - ld0), 32'd1);

    // 4: destination becomes ready after a few WAIT cycles
    dst_ready = 8'hFB;
    dr0 = n_drop; ld0 = n_load;
    in_valid = 1'b1; in_data = 8'h22; in_dest = 3'd2;
    tick();
    p = cyc;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    dst_ready = 8'hFF;
    tick();
    chk("t4_load", 32'(load), 32'h04);
    chk("t4_time", 32'(cyc - p), 32'd7);
    drain("t4");
    chk("t4_no_drop", 32'(n_drop - dr0), 32'd0);
    chk("t4_one_load", 32'(n_load - ld0), 32'd1);

    // 5: asynchronous reset while a byte waits and the FIFO is full
    dst_ready = 8'h00;
    in_valid = 1'b1;
    for (int k = 0; k < 12 && in_ready; k++) begin
      in_data = 8'($urandom); in_dest = 3'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("t5_full", 32'(count), 32'd4);
    chk("t5_busy", 32'(busy), 32'd1);
    #1 clr_n = 1'b0;
    #1;
    chk("t5_rst_load", 32'(load), 32'd0);
    chk("t5_rst_drop", 32'(drop), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    #1 clr_n = 1'b1;
    dst_ready = 8'hFF;
    ld0 = n_load; dr0 = n_drop;
    tick();
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 12; k++) tick();
    chk("t5_no_stale_load", 32'(n_load - ld0), 32'd0);
    chk("t5_no_stale_drop", 32'(n_drop - dr0), 32'd0);

    // 6: in_valid held through the pop of a full FIFO -> count 4,3,4
    in_valid = 1'b1;
    for (int k = 0; k < 20 && count != 3'd4; k++) begin
      in_data = 8'($urandom); in_dest = 3'($urandom);
      tick();
    end
    chk("t6_reach_full", 32'(count), 32'd4);
    chk("t6_not_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t6_pop_no_push", 32'(count), 32'd3);
    tick();
    chk("t6_push_next", 32'(count), 32'd4);
    in_valid = 1'b0;
    drain("t6");

    // randomized segments; ready mask constant while traffic is in flight
    for (int s = 0; s < 6; s++) begin
      dst_ready = 8'($urandom);
      for (int k = 0; k < 20; k++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
        in_dest = 3'($urandom);
        tick();
      end
      in_valid = 1'b0;
      drain("rand");
      chk("rand_count", 32'(count), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
